// File: rtl/i2c_controller.sv
// I2C write-only initiator: one (register, data) byte pair per request.
// Optional target clock stretching is compiled in with I2C_CLK_STRETCH_EN.
module i2c_controller #(
    parameter int         CLK_DIV     = 4,
    parameter int         DATA_WIDTH  = 8,
    parameter int         ADDR_WIDTH  = 5,
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_done,
    output logic                  o_nack,
    output logic                  o_busy,
    output logic                  o_scl_oe,
    output logic                  o_sda_oe,
    input  logic                  i_scl,
    input  logic                  i_sda
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_REG   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam int DW = $clog2(CLK_DIV);

    logic [2:0]            state;
    logic [DW-1:0]         div;
    logic [1:0]            q;
    logic [3:0]            bit_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [7:0]            cur_byte;
    logic                  in_byte;
    logic                  is_ack;
    logic                  q_end;
    logic                  sym_end;
    logic                  stall;

    assign in_byte = (state == S_ADDR) || (state == S_REG) || (state == S_DATA);
    assign is_ack  = in_byte && (bit_cnt == 4'd8);
    assign q_end   = (div == DW'(CLK_DIV - 1));
    assign sym_end = q_end && (q == 2'd3);
    assign o_ready = (state == S_IDLE);
    assign o_busy  = (state != S_IDLE);

`ifdef I2C_CLK_STRETCH_EN
    // Hold at the first clock of each SCL-high window until the line is seen high.
    assign stall = (div == '0) && !i_scl &&
                   ((in_byte && q == 2'd2) || (state == S_STOP && q == 2'd1));
`else
    logic unused_scl;
    assign unused_scl = i_scl;
    assign stall      = 1'b0;
`endif

    always_comb begin
        cur_byte = 8'(data_q);
        unique case (state)
            S_ADDR:  cur_byte = {TARGET_ADDR, 1'b0};
            S_REG:   cur_byte = 8'(addr_q);
            default: cur_byte = 8'(data_q);
        endcase
    end

    always_comb begin
        o_scl_oe = 1'b0;
        o_sda_oe = 1'b0;
        unique case (state)
            S_START: begin
                o_sda_oe = q[1];
                o_scl_oe = (q == 2'd3);
            end
            S_ADDR, S_REG, S_DATA: begin
                o_scl_oe = ~q[1];
                o_sda_oe = is_ack ? 1'b0 : ~cur_byte[3'(4'd7 - bit_cnt)];
            end
            S_STOP: begin
                o_scl_oe = (q == 2'd0);
                o_sda_oe = ~q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            div     <= '0;
            q       <= '0;
            bit_cnt <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            o_done  <= 1'b0;
            o_nack  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == S_IDLE) begin
                div     <= '0;
                q       <= '0;
                bit_cnt <= '0;
                if (i_valid) begin
                    state  <= S_START;
                    addr_q <= i_addr;
                    data_q <= i_data;
                    o_nack <= 1'b0;
                end
            end else if (!stall) begin
                div <= q_end ? '0 : div + 1'b1;
                if (q_end)
                    q <= q + 2'd1;
                if (sym_end) begin
                    unique case (state)
                        S_START: begin
                            state   <= S_ADDR;
                            bit_cnt <= '0;
                        end
                        S_STOP: begin
                            state  <= S_IDLE;
                            o_done <= 1'b1;
                        end
                        default: begin
                            if (is_ack) begin
                                bit_cnt <= '0;
                                if (i_sda) begin
                                    o_nack <= 1'b1;
                                    state  <= S_STOP;
                                end else begin
                                    unique case (state)
                                        S_ADDR:  state <= S_REG;
                                        S_REG:   state <= S_DATA;
                                        default: state <= S_STOP;
                                    endcase
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/i2c_controller.md
Name: i2c_controller

Overview:
- I2C controller (initiator) that writes one data byte to one register address of the MVM chip's I2C target over two open-drain lines.
- Used by the on-board sequencer and the verification environment to load matrix and vector entries into the target side.
- Accepts (address, data) words over a valid/ready handshake.
- Each word becomes one I2C transaction: START, device address + W, ACK, register byte, ACK, data byte, ACK, STOP.
- Reports completion and NACK status.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; must be >= 2.
- DATA_WIDTH, 8: data byte width; fixed at 8 for I2C framing.
- ADDR_WIDTH, 5: register address width; must be <= 8; zero-extended to 8 bits on the wire.
- TARGET_ADDR, 7'h42: 7-bit I2C device address of the target.

Ports:
- i_clk, input, 1: system clock.
- i_rst, input, 1: reset, synchronous, active-high.
- i_valid, input, 1: request valid.
- o_ready, output, 1: controller idle and able to accept a request.
- i_addr, input, ADDR_WIDTH: target register address.
- i_data, input, DATA_WIDTH: byte to write.
- o_done, output, 1: one-cycle pulse when a transaction ends.
- o_nack, output, 1: NACK status of the last transaction; valid with o_done, held until the next accept.
- o_busy, output, 1: transaction in progress.
- o_scl_oe, output, 1: 1 = pull SCL low; 0 = release.
- o_sda_oe, output, 1: 1 = pull SDA low; 0 = release.
- i_scl, input, 1: SCL line readback.
- i_sda, input, 1: SDA line readback.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_ready=1, o_done=0, o_nack=0, o_busy=0, o_scl_oe=0, o_sda_oe=0, state IDLE.
- Reset mid-transaction: both lines released on the next edge; the in-flight transaction is dropped with no o_done.
- Handshake:
  - Accept occurs on a cycle with i_valid && o_ready.
  - i_addr and i_data are latched in that cycle.
  - The cycle after accept: o_ready=0, o_busy=1, o_nack=0.
  - i_valid while busy is ignored; no queuing.
- Quarter counter: counts 0..CLK_DIV-1. A "symbol" is 4 quarters (q0..q3) = 4*CLK_DIV clocks.
- State machine: IDLE -> START -> ADDR(9) -> REG(9) -> DATA(9) -> STOP -> IDLE. Numbers in parentheses are bit-symbol counts (8 bits + 1 ACK).
- START symbol:
  - q0-q1: both lines released.
  - q2: SDA low, SCL released.
  - q3: SDA low, SCL low.
- Bit symbols:
  - q0-q1: SCL low; SDA driven, with sda_oe = ~bit.
  - q2-q3: SCL released.
  - Bits are sent MSB first.
- ADDR byte = {TARGET_ADDR, 1'b0}. REG byte = zero-extended i_addr. DATA byte = i_data.
- ACK symbols:
  - SDA released in all quarters.
  - i_sda sampled on the last clock of q3.
  - 0 = ACK; 1 = NACK.
- NACK: the next symbol is STOP regardless of remaining bytes, and o_nack=1.
- STOP symbol:
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low.
  - q2-q3: both lines released.
- Completion:
  - o_done pulses on the cycle after the last STOP quarter.
  - o_ready=1 and o_busy=0 from the same cycle.
- Latency, accept to o_done:
  - Full transaction: 29*4*CLK_DIV clocks (464 at CLK_DIV=4).
  - Address NACK: 11*4*CLK_DIV clocks.
  - Register NACK: 20*4*CLK_DIV clocks.
- Back-to-back: i_valid held high causes a new accept in the o_done cycle. Bus idle time between STOP and the next START equals the START q0-q1 window.
- Unused: i_scl is ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- When defined:
  - On entering q2 of any bit, ACK or STOP-q1 quarter, the quarter counter stalls while i_scl==0. This honours target clock stretching.
  - Counting resumes on the first cycle with i_scl==1.
  - Latency grows by exactly the number of stalled cycles.
- When undefined:
  - i_scl is unused; timing is fixed as specified above.

Test Plan:
- Reset, idle: i_rst high 3 cycles -> all outputs at reset values; o_ready=1; both oe=0.
- Full write: i_addr=5'h13, i_data=8'hA5, bus model ACKs all bytes -> serial bytes 0x84, 0x13, 0xA5 decoded MSB first; o_done at 464 clocks after accept; o_nack=0.
- Address NACK: model leaves SDA high on the first ACK -> STOP follows immediately; o_done at 176 clocks; o_nack=1; no REG byte on the bus.
- Back-to-back: two requests with i_valid held high -> second START follows the first STOP; second accept occurs in the first o_done cycle; both transactions decoded correctly.
- Reset mid-byte: i_rst asserted during REG bit 3 -> next cycle o_scl_oe=0, o_sda_oe=0, o_ready=1; no o_done.
- Clock stretch (I2C_CLK_STRETCH_EN defined): model holds SCL low 50 clocks at DATA bit 0 -> o_done at 514 clocks; data still 0xA5.
